// File: rtl/fetch_unit.sv
// Instruction fetch stage: issues sequential word fetches to a pipelined memory,
// buffers in-order responses with their PCs, and flushes on redirect.
module fetch_unit #(
  parameter int unsigned          DATAWIDTH = 32,
  parameter int unsigned          DEPTH     = 4,
  parameter logic [DATAWIDTH-1:0] RESET_PC  = '0
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  output logic                 imem_req_o,
  output logic [DATAWIDTH-1:0] imem_addr_o,
  input  logic                 imem_gnt_i,
  input  logic                 imem_rvalid_i,
  input  logic [DATAWIDTH-1:0] imem_rdata_i,
  input  logic                 redirect_i,
  input  logic [DATAWIDTH-1:0] redirect_pc_i,
  output logic                 inst_valid_o,
  output logic [DATAWIDTH-1:0] inst_o,
  output logic [DATAWIDTH-1:0] inst_pc_o,
  input  logic                 inst_ready_i
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam logic [CW:0]   CREDIT_LIMIT = (CW+1)'(DEPTH);
  localparam logic [CW-1:0] DEPTH_C      = CW'(DEPTH);
  localparam logic [CW-1:0] ONE_C        = CW'(1);
  localparam logic [PW-1:0] ONE_P        = PW'(1);
  localparam logic [DATAWIDTH-1:0] STEP  = DATAWIDTH'(4);

  logic [DATAWIDTH-1:0] fetch_pc_q, fetch_pc_d;
  logic [DATAWIDTH-1:0] resp_pc_q, resp_pc_d;
  logic [CW-1:0]        outstanding_q, outstanding_d;
  logic [CW-1:0]        drop_cnt_q, drop_cnt_d;
  logic [CW-1:0]        count_q, count_d;
  logic [PW-1:0]        rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [DATAWIDTH-1:0] inst_mem_q [DEPTH];
  logic [DATAWIDTH-1:0] inst_mem_d [DEPTH];
  logic [DATAWIDTH-1:0] pc_mem_q   [DEPTH];
  logic [DATAWIDTH-1:0] pc_mem_d   [DEPTH];

  logic                 req, grant, push, pop;
  logic [DATAWIDTH-1:0] target_pc;
  logic                 unused_pc_lsbs;

  assign target_pc      = {redirect_pc_i[DATAWIDTH-1:2], 2'b00};
  assign unused_pc_lsbs = ^redirect_pc_i[1:0];

  // In-flight requests plus buffered entries never exceed DEPTH, so a push always has room.
  assign req   = !rst_i && !redirect_i &&
                 (({1'b0, outstanding_q} + {1'b0, count_q}) < CREDIT_LIMIT);
  assign grant = req && imem_gnt_i;
  assign push  = imem_rvalid_i && (drop_cnt_q == '0) && !redirect_i;
  assign pop   = inst_valid_o && inst_ready_i;

  assign imem_req_o   = req;
  assign imem_addr_o  = fetch_pc_q;
  assign inst_valid_o = (count_q != '0) && !redirect_i && !rst_i;
  assign inst_o       = inst_mem_q[rd_ptr_q];
  assign inst_pc_o    = pc_mem_q[rd_ptr_q];

  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    resp_pc_d     = resp_pc_q;
    outstanding_d = outstanding_q + CW'(grant) - CW'(imem_rvalid_i);
    drop_cnt_d    = drop_cnt_q;
    count_d       = count_q;
    rd_ptr_d      = rd_ptr_q;
    wr_ptr_d      = wr_ptr_q;
    inst_mem_d    = inst_mem_q;
    pc_mem_d      = pc_mem_q;

    if (redirect_i) begin
      // Everything still in flight belongs to the old path and must be discarded.
      fetch_pc_d = target_pc;
      resp_pc_d  = target_pc;
      drop_cnt_d = outstanding_q - CW'(imem_rvalid_i);
      count_d    = '0;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
    end else begin
      if (grant) begin
        fetch_pc_d = fetch_pc_q + STEP;
      end
      if (imem_rvalid_i && (drop_cnt_q != '0)) begin
        drop_cnt_d = drop_cnt_q - ONE_C;
      end
      if (push) begin
        inst_mem_d[wr_ptr_q] = imem_rdata_i;
        pc_mem_d[wr_ptr_q]   = resp_pc_q;
        wr_ptr_d             = wr_ptr_q + ONE_P;
        resp_pc_d            = resp_pc_q + STEP;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + ONE_P;
      end
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      fetch_pc_q    <= RESET_PC;
      resp_pc_q     <= RESET_PC;
      outstanding_q <= '0;
      drop_cnt_q    <= '0;
      count_q       <= '0;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      resp_pc_q     <= resp_pc_d;
      outstanding_q <= outstanding_d;
      drop_cnt_q    <= drop_cnt_d;
      count_q       <= count_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
    end
  end

  always_ff @(posedge clk_i) begin
    inst_mem_q <= inst_mem_d;
    pc_mem_q   <= pc_mem_d;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i && push && !pop) begin
      assert (count_q < DEPTH_C);
    end
  end

endmodule
